// File: rtl/aes_block_loader.sv
`default_nettype none
// ============================================================================
//  Module   : aes_block_loader
//  Purpose  : Drains the 8-bit plaintext FIFO and packs bytes big-endian into
//             BYTES-wide blocks for the AES core. On a host flush the partial
//             final block is padded (pad value = number of pad bytes) and
//             tagged as last. Blocks leave through a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_block_loader #(
    parameter int BYTES = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 enable,
    input  logic                 flush,
    input  logic                 fifo_empty,
    input  logic [7:0]           fifo_r_data,
    output logic                 fifo_r_enable,
    input  logic                 blk_ready,
    output logic                 blk_valid,
    output logic [8*BYTES-1:0]   blk_data,
    output logic                 blk_last,
    output logic                 flush_done,
    output logic [CNT_W-1:0]     blk_count,
    output logic                 busy
);

    localparam int         C_CW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [1:0] C_FILL = 2'd0;
    localparam logic [1:0] C_PAD  = 2'd1;
    localparam logic [1:0] C_OUT  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [C_CW-1:0]     count_q, count_d;
    logic [8*BYTES-1:0]  data_q, data_d;
    logic                last_q, last_d;
    logic                pend_q, pend_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    bcnt_q, bcnt_d;

    logic                w_pop;
    logic                w_full;
    logic                w_flush_go;
    logic [7:0]          w_pad;

    // A pop always wins over a flush: flush only acts once the FIFO is empty.
    assign w_pop      = (state_q == C_FILL) & enable & ~fifo_empty;
    assign w_full     = (count_q == C_CW'(BYTES - 1));
    assign w_flush_go = (state_q == C_FILL) & enable & fifo_empty & pend_q;
    assign w_pad      = 8'(BYTES) - 8'(count_q);

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= C_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_FILL: begin
                if (w_pop) begin
                    if (w_full) state_d = C_OUT;
                end else if (w_flush_go && (count_q != '0)) begin
                    state_d = C_PAD;
                end
            end
            C_PAD:   state_d = C_OUT;
            C_OUT:   if (blk_ready) state_d = C_FILL;
            default: state_d = C_FILL;
        endcase
    end

    // FSM outputs
    always_comb begin
        fifo_r_enable = w_pop;
        blk_valid     = (state_q == C_OUT);
        busy          = (count_q != '0) | (state_q != C_FILL) | pend_q;
    end

    // Datapath next values: byte packing, padding, flush bookkeeping
    always_comb begin
        count_d = count_q;
        data_d  = data_q;
        last_d  = last_q;
        done_d  = 1'b0;
        pend_d  = pend_q | flush;
        bcnt_d  = bcnt_q;
        case (state_q)
            C_FILL: begin
                if (w_pop) begin
                    for (int i = 0; i < BYTES; i++) begin
                        if (count_q == C_CW'(i)) data_d[8*(BYTES-1-i) +: 8] = fifo_r_data;
                    end
                    count_d = w_full ? '0 : count_q + C_CW'(1);
                    if (w_full) last_d = 1'b0;
                end else if (w_flush_go && (count_q == '0)) begin
                    // Nothing buffered: finish the flush without a block.
                    // A pulse arriving in this same cycle stays pending.
                    done_d = 1'b1;
                    pend_d = flush;
                end
            end
            C_PAD: begin
                for (int i = 0; i < BYTES; i++) begin
                    if (C_CW'(i) >= count_q) data_d[8*(BYTES-1-i) +: 8] = w_pad;
                end
                count_d = '0;
                last_d  = 1'b1;
            end
            C_OUT: begin
                if (blk_ready) begin
                    bcnt_d = bcnt_q + CNT_W'(1);
                    if (last_q) begin
                        done_d = 1'b1;
                        pend_d = flush;
                        last_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            count_q <= count_d;
            data_q  <= data_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign blk_data   = data_q;
    assign blk_last   = last_q;
    assign flush_done = done_q;
    assign blk_count  = bcnt_q;

endmodule
`default_nettype wire
